axi_lite_master: RTL and testbench

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 188 ++++++++++++++++++
 tb/tb_axi_lite_master.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns one command at a time into an AXI-Lite read or write
// burst of one beat and returns a single response. All outputs are registered.
module axi_lite_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   // command side
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // response side
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   // AXI-Lite write address channel
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [2:0]              m_awprot,
   // AXI-Lite write data channel
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   // AXI-Lite write response channel
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   // AXI-Lite read address channel
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [2:0]              m_arprot,
   // AXI-Lite read data channel
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      StIdle,
      StWrReq,
      StWrResp,
      StRdReq,
      StRdResp,
      StRsp
   } state_e;

   state_e                  state_q;
   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic                    rsp_write_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]              rsp_resp_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic                    awvalid_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [StrbWidth-1:0]    wstrb_q;
   logic                    wvalid_q;
   logic                    bready_q;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic                    arvalid_q;
   logic                    rready_q;

   // A channel counts as done once its valid has dropped or it handshakes now
   logic aw_done;
   logic w_done;
   assign aw_done = !awvalid_q || m_awready;
   assign w_done  = !wvalid_q || m_wready;

   // Single FSM register block; every output comes straight from a flop
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
         awaddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  rsp_write_q <= cmd_write;
                  if (cmd_addr[1:0] != 2'b00) begin
                     // Misaligned: answer SLVERR locally, never touch the bus
                     rsp_valid_q <= 1'b1;
                     rsp_resp_q  <= 2'b10;
                     rsp_rdata_q <= '0;
                     state_q     <= StRsp;
                  end else if (cmd_write) begin
                     awaddr_q  <= cmd_addr;
                     wdata_q   <= cmd_wdata;
                     wstrb_q   <= cmd_wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= StWrReq;
                  end else begin
                     araddr_q  <= cmd_addr;
                     arvalid_q <= 1'b1;
                     state_q   <= StRdReq;
                  end
               end
            end
            StWrReq: begin
               if (m_awready) awvalid_q <= 1'b0;
               if (m_wready)  wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  state_q  <= StWrResp;
               end
            end
            StWrResp: begin
               if (m_bvalid && bready_q) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= m_bresp;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StRsp;
               end
            end
            StRdReq: begin
               if (m_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= StRdResp;
               end
            end
            StRdResp: begin
               if (m_rvalid && rready_q) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= m_rdata;
                  rsp_resp_q  <= m_rresp;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StRsp;
               end
            end
            StRsp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign m_awaddr  = awaddr_q;
   assign m_awvalid = awvalid_q;
   assign m_awprot  = 3'b000;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_wvalid  = wvalid_q;
   assign m_bready  = bready_q;
   assign m_araddr  = araddr_q;
   assign m_arvalid = arvalid_q;
   assign m_arprot  = 3'b000;
   assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master with a delay-configurable AXI-Lite slave
// and a scoreboard queue of expected responses.
module tb_axi_lite_master;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } exp_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready = 1'b0;
   logic [2:0]  m_awprot;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready = 1'b0;
   logic [1:0]  m_bresp = 2'b00;
   logic        m_bvalid = 1'b0;
   logic        m_bready;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready = 1'b0;
   logic [2:0]  m_arprot;
   logic [31:0] m_rdata = '0;
   logic [1:0]  m_rresp = 2'b00;
   logic        m_rvalid = 1'b0;
   logic        m_rready;

   axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 aclk = ~aclk;

   logic [147:0] all_out;
   assign all_out = {cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                     m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready,
                     m_araddr, m_arvalid, m_arprot, m_rready};

   int n_cmp = 0;
   int n_err = 0;
   exp_t exp_q[$];

   // Slave configuration and state
   int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
   int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   logic [1:0]  rresp_cfg = 2'b00;
   logic [31:0] rdata_cfg = '0;

   // Slave: each ready/valid rises after its channel has waited the configured cycles
   always @(negedge aclk) begin
      if (!aresetn) begin
         m_awready <= 1'b0; m_wready <= 1'b0; m_arready <= 1'b0;
         m_bvalid <= 1'b0; m_rvalid <= 1'b0;
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0; b_wait <= 0;
      end else begin
         m_awready <= m_awvalid && (aw_wait >= aw_delay);
         aw_wait   <= m_awvalid ? aw_wait + 1 : 0;
         m_wready  <= m_wvalid && (w_wait >= w_delay);
         w_wait    <= m_wvalid ? w_wait + 1 : 0;
         m_arready <= m_arvalid && (ar_wait >= ar_delay);
         ar_wait   <= m_arvalid ? ar_wait + 1 : 0;
         m_bvalid  <= m_bready && (b_wait >= b_delay);
         m_bresp   <= bresp_cfg;
         b_wait    <= m_bready ? b_wait + 1 : 0;
         m_rvalid  <= m_rready && (r_wait >= r_delay);
         m_rdata   <= rdata_cfg;
         m_rresp   <= rresp_cfg;
         r_wait    <= m_rready ? r_wait + 1 : 0;
      end
   end

   // Bus monitor: handshake counts, bus activity and protocol rule violations
   int aw_hs = 0, w_hs = 0, ar_hs = 0, axi_act = 0, proto_err = 0;
   logic aw_done = 1'b0, w_done = 1'b0;
   logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   logic [31:0] aw_addr_p = '0, w_data_p = '0, ar_addr_p = '0;
   logic [3:0]  w_strb_p = '0;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_done <= 1'b0; w_done <= 1'b0;
         aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      end else begin
         if (aw_pend && (!m_awvalid || m_awaddr !== aw_addr_p)) proto_err <= proto_err + 1;
         if (w_pend && (!m_wvalid || m_wdata !== w_data_p || m_wstrb !== w_strb_p))
            proto_err <= proto_err + 1;
         if (ar_pend && (!m_arvalid || m_araddr !== ar_addr_p)) proto_err <= proto_err + 1;
         if (m_bready && !(aw_done && w_done)) proto_err <= proto_err + 1;
         if (cmd_valid && cmd_ready) begin
            aw_done <= 1'b0; w_done <= 1'b0;
         end
         if (m_awvalid && m_awready) begin aw_hs <= aw_hs + 1; aw_done <= 1'b1; end
         if (m_wvalid && m_wready) begin w_hs <= w_hs + 1; w_done <= 1'b1; end
         if (m_arvalid && m_arready) ar_hs <= ar_hs + 1;
         if (m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready) axi_act <= axi_act + 1;
         aw_pend <= m_awvalid && !m_awready; aw_addr_p <= m_awaddr;
         w_pend  <= m_wvalid && !m_wready;   w_data_p <= m_wdata; w_strb_p <= m_wstrb;
         ar_pend <= m_arvalid && !m_arready; ar_addr_p <= m_araddr;
      end
   end

   // Drive one command; returns on the falling edge after acceptance
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
      int i;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      i = 0;
      while (!cmd_ready && i < 100) begin
         @(negedge aclk);
         i++;
      end
      if (!cmd_ready) begin
         n_cmp++; n_err++;
         $display("FAIL cmd_accept_timeout: got cmd_ready=%b required 1", cmd_ready);
      end else begin
         @(negedge aclk);
      end
      cmd_valid = 1'b0;
   endtask

   // Wait for a response, hold rsp_ready low for 'hold' cycles, then consume it
   task automatic collect_rsp(input int hold, output logic got_wr, output logic [31:0] got_rd,
                              output logic [1:0] got_resp, output logic held_ok,
                              output logic post_ready, output logic post_valid);
      int i;
      got_wr = 1'b0; got_rd = '0; got_resp = 2'b00; held_ok = 1'b1;
      post_ready = 1'b0; post_valid = 1'b1;
      i = 0;
      while (!rsp_valid && i < 200) begin
         @(negedge aclk);
         i++;
      end
      if (!rsp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL rsp_timeout: got rsp_valid=%b required 1", rsp_valid);
         held_ok = 1'b0;
         return;
      end
      got_wr = rsp_write; got_rd = rsp_rdata; got_resp = rsp_resp;
      repeat (hold) begin
         @(negedge aclk);
         if (!rsp_valid || rsp_write !== got_wr || rsp_rdata !== got_rd || rsp_resp !== got_resp)
            held_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge aclk);
      rsp_ready = 1'b0;
      post_ready = cmd_ready;
      post_valid = rsp_valid;
   endtask

   logic        g_wr, g_held, g_pr, g_pv;
   logic [31:0] g_rd;
   logic [1:0]  g_resp;
   exp_t        e;

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (3) @(negedge aclk);
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL reset_outputs: got %h required 0", all_out);
      end
      aresetn = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
         n_err++; $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
      end
      @(negedge aclk);
      n_cmp++;
      if ({cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 7'b1000000)
      begin
         n_err++; $display("FAIL ready_after_edge: got %b required 1000000",
                           {cmd_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
      end
   endtask

   task automatic test_write();
      int aw0, w0, pe0;
      aw_delay = 0; w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;
      aw0 = aw_hs; w0 = w_hs; pe0 = proto_err;
      exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b00});
      send_cmd(1'b1, 32'h0, 32'h1, 4'hF);
      n_cmp++;
      if ({m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb, m_awprot} !==
          {2'b11, 32'h0, 32'h1, 4'hF, 3'b000}) begin
         n_err++; $display("FAIL write_req: got %b %b %h %h %h required 1 1 0 1 f",
                           m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb);
      end
      collect_rsp(0, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL write_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      n_cmp++;
      if (aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
         n_err++; $display("FAIL write_beats: got aw=%0d w=%0d required 1 1", aw_hs - aw0, w_hs - w0);
      end
      n_cmp++;
      if ({g_pr, g_pv} !== 2'b10) begin
         n_err++; $display("FAIL write_return_idle: got %b required 10", {g_pr, g_pv});
      end
      n_cmp++;
      if (proto_err != pe0) begin
         n_err++; $display("FAIL write_protocol: got %0d violations required 0", proto_err - pe0);
      end
   endtask

   task automatic test_read();
      int ar0, aw0;
      logic held;
      ar_delay = 3; r_delay = 3; rdata_cfg = 32'hDEADBEEF; rresp_cfg = 2'b00;
      ar0 = ar_hs; aw0 = aw_hs;
      exp_q.push_back('{wr: 1'b0, rdata: 32'hDEADBEEF, resp: 2'b00});
      send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
      n_cmp++;
      if ({m_arvalid, m_araddr, m_arprot} !== {1'b1, 32'h8, 3'b000}) begin
         n_err++; $display("FAIL read_req: got %b %h required 1 00000008", m_arvalid, m_araddr);
      end
      held = 1'b1;
      repeat (3) begin
         @(negedge aclk);
         if (!m_arvalid) held = 1'b0;
      end
      n_cmp++;
      if (held !== 1'b1) begin
         n_err++; $display("FAIL arvalid_hold: got %b required 1", held);
      end
      collect_rsp(0, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL read_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      n_cmp++;
      if (ar_hs - ar0 != 1 || aw_hs != aw0) begin
         n_err++; $display("FAIL read_beats: got ar=%0d aw=%0d required 1 0", ar_hs - ar0, aw_hs - aw0);
      end
   endtask

   task automatic test_split_write();
      int pe0;
      aw_delay = 2; w_delay = 0; b_delay = 1; bresp_cfg = 2'b01;
      pe0 = proto_err;
      exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b01});
      send_cmd(1'b1, 32'h10, 32'hA5A5_0F0F, 4'b0011);
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         n_cmp++;
         if ({m_awvalid, m_wvalid, m_bready} !== ((c < 2) ? 3'b100 : 3'b001)) begin
            n_err++; $display("FAIL split_cycle%0d: got %b required %b", c,
                              {m_awvalid, m_wvalid, m_bready}, (c < 2) ? 3'b100 : 3'b001);
         end
      end
      collect_rsp(0, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL split_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      n_cmp++;
      if (proto_err != pe0) begin
         n_err++; $display("FAIL split_protocol: got %0d violations required 0", proto_err - pe0);
      end
      aw_delay = 0; b_delay = 0;
   endtask

   task automatic test_misaligned();
      int act0;
      act0 = axi_act;
      exp_q.push_back('{wr: 1'b1, rdata: 32'h0, resp: 2'b10});
      send_cmd(1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF);
      collect_rsp(0, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL misaligned_wr_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      exp_q.push_back('{wr: 1'b0, rdata: 32'h0, resp: 2'b10});
      rdata_cfg = 32'h1234_5678;
      send_cmd(1'b0, 32'h21, 32'h0, 4'h0);
      collect_rsp(0, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL misaligned_rd_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      n_cmp++;
      if (axi_act != act0) begin
         n_err++; $display("FAIL misaligned_no_bus: got %0d active cycles required 0", axi_act - act0);
      end
   endtask

   task automatic test_backpressure();
      ar_delay = 0; r_delay = 1; rresp_cfg = 2'b11; rdata_cfg = 32'h0BAD_F00D;
      exp_q.push_back('{wr: 1'b0, rdata: 32'h0BAD_F00D, resp: 2'b11});
      send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
      collect_rsp(4, g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
      e = exp_q.pop_front();
      n_cmp++;
      if ({g_wr, g_rd, g_resp} !== e) begin
         n_err++; $display("FAIL bp_rsp: got %h required %h", {g_wr, g_rd, g_resp}, e);
      end
      n_cmp++;
      if (g_held !== 1'b1) begin
         n_err++; $display("FAIL bp_stable: got %b required 1", g_held);
      end
      n_cmp++;
      if ({g_pr, g_pv} !== 2'b10) begin
         n_err++; $display("FAIL bp_return_idle: got %b required 10", {g_pr, g_pv});
      end
      rresp_cfg = 2'b00; r_delay = 0;
   endtask

   task automatic test_reset_mid();
      logic seen;
      aw_delay = 1000; w_delay = 1000;
      send_cmd(1'b1, 32'h40, 32'hCAFE_0001, 4'hF);
      n_cmp++;
      if (m_awvalid !== 1'b1) begin
         n_err++; $display("FAIL mid_awvalid: got %b required 1", m_awvalid);
      end
      #2;
      aresetn = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++; $display("FAIL mid_reset_outputs: got %h required 0", all_out);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      aw_delay = 0; w_delay = 0;
      @(negedge aclk);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_ready: got %b required 1", cmd_ready);
      end
      seen = 1'b0;
      repeat (5) begin
         @(negedge aclk);
         if (rsp_valid || m_awvalid || m_wvalid || m_bready) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL mid_stale: got activity=%b required 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int aw0, nwr, pe0;
      logic        wr;
      logic [31:0] addr, data, rd;
      logic [1:0]  resp;
      aw0 = aw_hs; nwr = 0; pe0 = proto_err;
      for (int k = 0; k < 8; k++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         data = $urandom;
         rd   = $urandom;
         resp = 2'($urandom_range(0, 3));
         aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
         ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
         b_delay  = $urandom_range(0, 3);
         bresp_cfg = resp; rresp_cfg = resp; rdata_cfg = rd;
         if (wr) nwr++;
         exp_q.push_back('{wr: wr, rdata: wr ? 32'h0 : rd, resp: resp});
         send_cmd(wr, addr, data, 4'($urandom_range(0, 15)));
         collect_rsp(int'($urandom_range(0, 2)), g_wr, g_rd, g_resp, g_held, g_pr, g_pv);
         e = exp_q.pop_front();
         n_cmp++;
         if ({g_wr, g_rd, g_resp} !== e || g_pr !== 1'b1) begin
            n_err++; $display("FAIL b2b_rsp%0d: got %h ready=%b required %h ready=1",
                              k, {g_wr, g_rd, g_resp}, g_pr, e);
         end
      end
      n_cmp++;
      if (aw_hs - aw0 != nwr || proto_err != pe0) begin
         n_err++; $display("FAIL b2b_beats: got aw=%0d viol=%0d required aw=%0d viol=0",
                           aw_hs - aw0, proto_err - pe0, nwr);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_split_write();
      test_misaligned();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
